// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Clear-sequencer state encoding and depth helper.
package regfile_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  function automatic int rf_depth(int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bundle for regfile_mp.
// master drives addresses and strobes, slave is the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     init_done;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;

  modport master (
    input  init_done, rd_data, rd_busy,
    output rd_addr, wr_en, wr_addr, wr_data,
    output iss_en, iss_addr
  );

  modport slave (
    output init_done, rd_data, rd_busy,
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  iss_en, iss_addr
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue,
// cleared on writeback; issue wins on a same-edge collision.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);
  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DEPTH-1:0] busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      if (wr)  busy_q[wr_addr]  <= 1'b0;
      if (iss) busy_q[iss_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_busy[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with bypass, zero register,
// busy scoreboard and a post-reset clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W:0] LAST =
    (ADDR_W+1)'(DEPTH-1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W:0]   clr_q, clr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready, wr_ok, iss_ok;
  logic [NUM_RD-1:0] sb_busy;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      RF_INIT: begin
        clr_d = clr_q + (ADDR_W+1)'(1);
        if (clr_q == LAST) state_d = RF_READY;
      end
      RF_READY: ;
    endcase
  end

  assign ready  = (state_q == RF_READY);
  assign wr_ok  = ready && bus.wr_en &&
                  !is_zero(bus.wr_addr);
  assign iss_ok = ready && bus.iss_en &&
                  !is_zero(bus.iss_addr);

  // Storage is never reset; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!ready)
      mem[clr_q[ADDR_W-1:0]] <= '0;
    else if (wr_ok)
      mem[bus.wr_addr] <= bus.wr_data;
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss      (iss_ok),
    .iss_addr (bus.iss_addr),
    .wr       (wr_ok),
    .wr_addr  (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (sb_busy)
  );

  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;
  logic [ADDR_W-1:0]        a;

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    a         = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (ready && !is_zero(a)) begin
        if (BYPASS != 0 && wr_ok && bus.wr_addr == a) begin
          rd_data_c[i*DATA_W +: DATA_W] = bus.wr_data;
        end else begin
          rd_data_c[i*DATA_W +: DATA_W] = mem[a];
          rd_busy_c[i] = sb_busy[i];
        end
      end
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.rd_busy   = rd_busy_c;
  assign bus.init_done = ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp: two configurations driven in
// lockstep and compared against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4)) b0 ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2)) b1 ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(4),
    .ZERO_REG(1), .BYPASS(1)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(2),
    .ZERO_REG(0), .BYPASS(0)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int n_chk = 0;
  int n_err = 0;

  logic          we, ie;
  logic [AW-1:0] wa, ia;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra [4];

  logic [DW-1:0] m_mem  [2][DEPTH];
  bit            m_busy [2][DEPTH];
  int            m_cnt;
  bit            zr  [2] = '{1'b1, 1'b0};
  bit            byp [2] = '{1'b1, 1'b0};

  task automatic chk(string tag, logic [DW-1:0] got,
                     logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(int d,
                                             logic [AW-1:0] a);
    if (m_cnt < DEPTH) return '0;
    if (zr[d] && a == 0) return '0;
    if (byp[d] && we && wa == a) return wd;
    return m_mem[d][a];
  endfunction

  function automatic logic exp_busy(int d, logic [AW-1:0] a);
    if (m_cnt < DEPTH) return 1'b0;
    if (zr[d] && a == 0) return 1'b0;
    if (byp[d] && we && wa == a) return 1'b0;
    return m_busy[d][a];
  endfunction

  function automatic logic [DW-1:0] got_data(int d, int i);
    if (d == 0) return b0.rd_data[i*DW +: DW];
    return b1.rd_data[i*DW +: DW];
  endfunction

  function automatic logic got_busy(int d, int i);
    if (d == 0) return b0.rd_busy[i];
    return b1.rd_busy[i];
  endfunction

  task automatic m_reset();
    m_cnt = 0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[d][r]  = '0;
        m_busy[d][r] = 1'b0;
      end
  endtask

  task automatic apply();
    b0.wr_en = we;  b0.wr_addr = wa;  b0.wr_data = wd;
    b0.iss_en = ie; b0.iss_addr = ia;
    b0.rd_addr = {ra[3], ra[2], ra[1], ra[0]};
    b1.wr_en = we;  b1.wr_addr = wa;  b1.wr_data = wd;
    b1.iss_en = ie; b1.iss_addr = ia;
    b1.rd_addr = {ra[1], ra[0]};
  endtask

  task automatic set(logic w, logic [AW-1:0] wad,
                     logic [DW-1:0] wdat, logic i,
                     logic [AW-1:0] iad, logic [AW-1:0] r0,
                     logic [AW-1:0] r1, logic [AW-1:0] r2,
                     logic [AW-1:0] r3);
    we = w; wa = wad; wd = wdat; ie = i; ia = iad;
    ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
  endtask

  task automatic rnd();
    we = 1'($urandom_range(0, 1));
    wa = AW'($urandom_range(0, 7));
    wd = $urandom;
    ie = 1'($urandom_range(0, 1));
    ia = AW'($urandom_range(0, 7));
    for (int i = 0; i < 4; i++)
      ra[i] = AW'($urandom_range(0, 7));
  endtask

  task automatic half_a();
    apply();
    @(negedge clk);
    chk("init_done0", 32'(b0.init_done), 32'(m_cnt >= DEPTH));
    chk("init_done1", 32'(b1.init_done), 32'(m_cnt >= DEPTH));
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < (d == 0 ? 4 : 2); i++) begin
        chk($sformatf("data d%0d p%0d a%0d", d, i, ra[i]),
            got_data(d, i), exp_data(d, ra[i]));
        chk($sformatf("busy d%0d p%0d a%0d", d, i, ra[i]),
            32'(got_busy(d, i)), 32'(exp_busy(d, ra[i])));
      end
  endtask

  task automatic half_b();
    @(posedge clk);
    if (rst_n) begin
      if (m_cnt < DEPTH) m_cnt++;
      else
        for (int d = 0; d < 2; d++) begin
          if (we && !(zr[d] && wa == 0)) begin
            m_mem[d][wa]  = wd;
            m_busy[d][wa] = 1'b0;
          end
          if (ie && !(zr[d] && ia == 0))
            m_busy[d][ia] = 1'b1;
        end
    end
    #1;
  endtask

  task automatic cyc();
    half_a();
    half_b();
  endtask

  task automatic reset_sweep(bit write_r3);
    rst_n = 1'b0;
    m_reset();
    rnd();
    cyc();
    rnd();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      rnd();
      if (write_r3) begin
        we = 1'b1; wa = 5'd3; wd = 32'hA;
      end
      half_a();
      chk("init_low", 32'(b0.init_done), 32'd0);
      half_b();
    end
  endtask

  initial begin
    m_reset();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply();
    @(posedge clk);
    #1;
    reset_sweep(1'b1);

    // Write during the sweep must have been dropped.
    set(0, 0, 0, 0, 0, 3, 3, 3, 3);
    half_a();
    chk("init_high", 32'(b0.init_done), 32'd1);
    chk("init_wr_drop", got_data(0, 0), 32'd0);
    half_b();

    set(1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 7, 7);
    half_a();
    chk("byp_on", got_data(0, 1), 32'hDEADBEEF);
    chk("byp_off", got_data(1, 1), 32'd0);
    half_b();
    set(0, 0, 0, 0, 0, 7, 7, 7, 7);
    half_a();
    chk("rd_r7", got_data(0, 0), 32'hDEADBEEF);
    half_b();

    set(1, 0, 32'h1234, 1, 0, 0, 0, 0, 0);
    cyc();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    half_a();
    chk("zero_rd", got_data(0, 0), 32'd0);
    chk("zero_busy", 32'(got_busy(0, 0)), 32'd0);
    chk("nozero_rd", got_data(1, 0), 32'h1234);
    half_b();

    set(0, 0, 0, 1, 5, 5, 5, 5, 5);
    cyc();
    set(0, 0, 0, 0, 0, 5, 5, 5, 5);
    half_a();
    chk("sb_set", 32'(got_busy(0, 0)), 32'd1);
    half_b();
    set(1, 5, 32'd9, 0, 0, 5, 5, 5, 5);
    cyc();
    set(0, 0, 0, 0, 0, 5, 5, 5, 5);
    half_a();
    chk("sb_clr", 32'(got_busy(0, 0)), 32'd0);
    half_b();
    set(1, 5, 32'd9, 1, 5, 5, 5, 5, 5);
    cyc();
    set(0, 0, 0, 0, 0, 5, 5, 5, 5);
    half_a();
    chk("sb_both_busy", 32'(got_busy(0, 0)), 32'd1);
    chk("sb_both_data", got_data(0, 0), 32'd9);
    half_b();

    set(1, 3, 32'hA, 0, 0, 3, 3, 3, 3);
    half_a();
    for (int i = 0; i < 4; i++)
      chk($sformatf("byp4 p%0d", i), got_data(0, i), 32'hA);
    half_b();

    for (int k = 0; k < 300; k++) begin
      rnd();
      cyc();
    end

    set(1, 3, 32'h55, 1, 9, 3, 9, 3, 9);
    cyc();
    set(0, 0, 0, 0, 0, 3, 9, 3, 9);
    half_a();
    chk("pre_rst_r3", got_data(0, 0), 32'h55);
    chk("pre_rst_busy", 32'(got_busy(0, 1)), 32'd1);
    half_b();
    reset_sweep(1'b0);
    set(0, 0, 0, 0, 0, 3, 9, 3, 9);
    half_a();
    chk("post_rst_r3", got_data(0, 0), 32'd0);
    chk("post_rst_busy", 32'(got_busy(0, 1)), 32'd0);
    half_b();

    for (int k = 0; k < 300; k++) begin
      rnd();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
